// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives every 2-input vector into a gate under test and checks its output against a truth table
module gate_sweep_checker #(
    parameter int unsigned SETTLE = 2,
    parameter logic [3:0]  TRUTH  = 4'b1001,
    parameter int unsigned LOOPS  = 1,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_out,
    output logic             in1,
    output logic             in2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       fail_vec,
    output logic             fail_valid
);
    localparam int unsigned SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int unsigned LW = LOOPS > 1 ? $clog2(LOOPS) : 1;
    localparam logic [SW-1:0] CNT_INIT = SW'(SETTLE - 1);
    localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [LW-1:0]    loop_q, loop_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic [1:0]       fvec_q, fvec_d;
    logic             fval_q, fval_d;
    logic             sample, mismatch, last;

    // sample point of the current vector, its check result and end-of-run detect
    always_comb begin
        sample   = state_q == WAIT && cnt_q == '0;
        mismatch = sample && (dut_out != TRUTH[vec_q]);
        last     = vec_q == 2'd3 && loop_q == LOOP_LAST;
    end

    // next state: start clears results, WAIT counts down the settle window then checks and advances
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pass_d  = pass_q;
        fvec_d  = fvec_q;
        fval_d  = fval_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = WAIT;
                vec_d   = '0;
                loop_d  = '0;
                cnt_d   = CNT_INIT;
                err_d   = '0;
                pass_d  = 1'b0;
                fvec_d  = '0;
                fval_d  = 1'b0;
            end
            WAIT: if (!sample) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                if (mismatch) begin
                    err_d = err_q == ERR_MAX ? err_q : err_q + 1'b1;
                    if (!fval_q) begin
                        fval_d = 1'b1;
                        fvec_d = vec_q;
                    end
                end
                if (last) begin
                    state_d = DONE;
                    pass_d  = err_q == '0 && !mismatch;
                end else begin
                    vec_d  = vec_q + 2'd1;
                    loop_d = vec_q == 2'd3 ? loop_q + 1'b1 : loop_q;
                    cnt_d  = CNT_INIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and result registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            loop_q  <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            fvec_q  <= '0;
            fval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fvec_q  <= fvec_d;
            fval_q  <= fval_d;
        end
    end

    // stimulus is a decode of registered state only, so start never reaches in1/in2 combinationally
    always_comb begin
        busy       = state_q == WAIT;
        done       = state_q == DONE;
        {in1, in2} = busy ? vec_q : 2'b00;
        pass       = pass_q;
        err_cnt    = err_q;
        fail_vec   = fvec_q;
        fail_valid = fval_q;
    end
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: four differently parameterised checkers against a cycle-indexed behavioural model
module tb_gate_sweep_checker;
    localparam int N = 4;
    localparam int S_P [N] = '{2, 2, 1, 3};
    localparam int L_P [N] = '{1, 2, 1, 3};
    localparam int C_P [N] = '{4, 2, 4, 3};
    localparam logic [3:0] T_P [N] = '{4'b1001, 4'b1001, 4'b1001, 4'b0110};

    logic clk = 1'b0;
    logic rst, start;
    logic dut_out [N];
    logic in1_w [N], in2_w [N], busy_w [N], done_w [N], pass_w [N], fval_w [N];
    logic [1:0] fv_w [N];
    logic [3:0] err_w [N];
    logic [3:0] e0, e2;
    logic [1:0] e1;
    logic [2:0] e3;
    logic reg_x [N], rnd [N];
    int mode [N];
    int tests = 0, fails = 0;

    int t [N], errs [N], fvec [N], fval [N], pss [N];
    int v_m;
    int done_at [N], sp [N], se [N], sfv [N], sfl [N];

    always #5 clk = ~clk;

    gate_sweep_checker #(.SETTLE(2), .TRUTH(4'b1001), .LOOPS(1), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out[0]), .in1(in1_w[0]), .in2(in2_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(e0), .fail_vec(fv_w[0]), .fail_valid(fval_w[0]));
    gate_sweep_checker #(.SETTLE(2), .TRUTH(4'b1001), .LOOPS(2), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out[1]), .in1(in1_w[1]), .in2(in2_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(e1), .fail_vec(fv_w[1]), .fail_valid(fval_w[1]));
    gate_sweep_checker #(.SETTLE(1), .TRUTH(4'b1001), .LOOPS(1), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out[2]), .in1(in1_w[2]), .in2(in2_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(e2), .fail_vec(fv_w[2]), .fail_valid(fval_w[2]));
    gate_sweep_checker #(.SETTLE(3), .TRUTH(4'b0110), .LOOPS(3), .CNT_W(3)) u3 (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out[3]), .in1(in1_w[3]), .in2(in2_w[3]),
        .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_cnt(e3), .fail_vec(fv_w[3]), .fail_valid(fval_w[3]));

    assign err_w[0] = e0;
    assign err_w[1] = {2'b00, e1};
    assign err_w[2] = e2;
    assign err_w[3] = {1'b0, e3};

    // gate models: 0 comb XNOR, 1 stuck 0, 2 stuck 1, 3 registered XNOR, 4 random
    always_comb
        for (int i = 0; i < N; i++)
            dut_out[i] = mode[i] == 0 ? ~(in1_w[i] ^ in2_w[i]) : mode[i] == 1 ? 1'b0 :
                         mode[i] == 2 ? 1'b1 : mode[i] == 3 ? reg_x[i] : rnd[i];

    always @(posedge clk)
        for (int i = 0; i < N; i++) reg_x[i] <= ~(in1_w[i] ^ in2_w[i]);

    always @(negedge clk)
        for (int i = 0; i < N; i++) rnd[i] <= 1'($urandom_range(0, 1));

    function automatic int nn_of(input int i);
        return 4 * L_P[i] * S_P[i];
    endfunction
    function automatic int busy_e(input int i);
        return (t[i] >= 1 && t[i] <= nn_of(i)) ? 1 : 0;
    endfunction
    function automatic int vec_e(input int i);
        return busy_e(i) ? ((t[i] - 1) / S_P[i]) % 4 : 0;
    endfunction
    function automatic int err_e(input int i);
        int mx = (1 << C_P[i]) - 1;
        return errs[i] < mx ? errs[i] : mx;
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s u%0d: got %0d, expected %0d at %0t", name, i, act, exp, $time);
        end
    endtask

    // model: t is the cycle number inside a run (0 = idle); vector and sample points follow from t alone
    always @(posedge clk or posedge rst)
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                t[i] = 0; errs[i] = 0; fvec[i] = 0; fval[i] = 0; pss[i] = 0;
            end else if (t[i] == 0) begin
                if (start) begin
                    t[i] = 1; errs[i] = 0; fvec[i] = 0; fval[i] = 0; pss[i] = 0;
                end
            end else if (t[i] <= nn_of(i)) begin
                if ((t[i] - 1) % S_P[i] == S_P[i] - 1) begin
                    v_m = ((t[i] - 1) / S_P[i]) % 4;
                    if (dut_out[i] != T_P[i][v_m]) begin
                        errs[i]++;
                        if (fval[i] == 0) begin
                            fval[i] = 1; fvec[i] = v_m;
                        end
                    end
                end
                t[i]++;
                if (t[i] == nn_of(i) + 1) pss[i] = errs[i] == 0 ? 1 : 0;
            end else begin
                t[i] = 0;
            end
        end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk)
        for (int i = 0; i < N; i++) begin
            chk("busy", i, busy_w[i], busy_e(i));
            chk("in1", i, in1_w[i], vec_e(i) >> 1);
            chk("in2", i, in2_w[i], vec_e(i) & 1);
            chk("done", i, done_w[i], t[i] == nn_of(i) + 1 ? 1 : 0);
            chk("pass", i, pass_w[i], pss[i]);
            chk("err_cnt", i, err_w[i], err_e(i));
            chk("fail_vec", i, fv_w[i], fvec[i]);
            chk("fail_valid", i, fval_w[i], fval[i]);
        end

    task automatic run(input int budget, input bit noisy);
        for (int i = 0; i < N; i++) done_at[i] = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (done_w[i] && done_at[i] < 0) begin
                    done_at[i] = c; sp[i] = pass_w[i]; se[i] = err_w[i]; sfv[i] = fv_w[i]; sfl[i] = fval_w[i];
                end
            if (noisy) start = $urandom_range(0, 5) == 0;
        end
        start = 1'b0;
        for (int i = 0; i < N; i++) chk("done_cycle", i, done_at[i], 1 + nn_of(i));
        if (noisy) repeat (40) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = '{0, 0, 0, 0};
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, busy_w[0], 0);
        chk("rst_err", 1, err_w[1], 0);
        rst = 1'b0;
        mode = '{0, 2, 3, 4};
        run(40, 0);
        chk("s1_pass", 0, sp[0], 1);
        chk("s1_err", 0, se[0], 0);
        chk("s1_fval", 0, sfl[0], 0);
        chk("s1_done9", 0, done_at[0], 9);
        chk("sat_err", 1, se[1], 3);
        chk("sat_fvec", 1, sfv[1], 1);
        chk("sat_pass", 1, sp[1], 0);
        chk("sat_done17", 1, done_at[1], 17);
        chk("reg1_err", 2, se[2], 2);
        chk("reg1_fvec", 2, sfv[2], 1);
        chk("reg1_done5", 2, done_at[2], 5);
        mode = '{1, 4, 0, 4};
        run(40, 0);
        chk("stuck0_err", 0, se[0], 2);
        chk("stuck0_fvec", 0, sfv[0], 0);
        chk("stuck0_fval", 0, sfl[0], 1);
        chk("stuck0_pass", 0, sp[0], 0);
        chk("comb_pass", 2, sp[2], 1);
        mode = '{3, 0, 4, 4};
        run(40, 0);
        chk("reg2_pass", 0, sp[0], 1);
        chk("comb_loop_pass", 1, sp[1], 1);
        @(negedge clk);
        start = 1'b1;
        repeat (90) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) mode[i] = $urandom_range(0, 4);
            run(40, 1);
        end
        mode = '{0, 1, 4, 4};
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 0, busy_w[0], 0);
        chk("arst_in2", 0, in2_w[0], 0);
        chk("arst_err", 1, err_w[1], 0);
        chk("arst_done", 2, done_w[2], 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mode = '{0, 0, 0, 4};
        run(40, 0);
        chk("post_rst_pass", 0, sp[0], 1);
        chk("post_rst_err", 0, se[0], 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
